// File: rtl/sram_mem_ctrl.sv
// Multi-cycle MEM-stage data memory controller: each 32-bit word access becomes
// two 16-bit half-accesses on an asynchronous SRAM, with ready low while busy.
module sram_mem_ctrl #(
    parameter int ADDR_BASE  = 1024,
    parameter int ACC_CYCLES = 3,
    parameter int SRAM_AW    = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    typedef logic [SRAM_AW-2:0] word_t;

    localparam logic [3:0] LAST = 4'(ACC_CYCLES - 1);

    state_t             state, state_n;
    logic [3:0]         cnt, cnt_n;
    logic               op_rd, op_rd_n;
    word_t              word, word_n;
    logic [31:0]        wdata, wdata_n;
    logic [31:0]        read_data_n;
    logic [SRAM_AW-1:0] sram_addr_n;
    logic [15:0]        sram_dq_o_n;
    logic               sram_dq_oe_n, sram_we_n_n, sram_oe_n_n;

    assign ready = (state == IDLE && !(rd_en || wr_en)) || state == DONE;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_n     = state;
        cnt_n       = cnt;
        op_rd_n     = op_rd;
        word_n      = word;
        wdata_n     = wdata;
        read_data_n = read_data;

        case (state)
            IDLE: begin
                if (rd_en || wr_en) begin
                    op_rd_n = rd_en;
                    word_n  = word_t'((address - 32'(ADDR_BASE)) >> 2);
                    wdata_n = write_data;
                    cnt_n   = 4'd0;
                    state_n = LO;
                end
            end
            LO: begin
                if (cnt == LAST) begin
                    cnt_n   = 4'd0;
                    state_n = HI;
                    if (op_rd) read_data_n[15:0] = sram_dq_i;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            HI: begin
                if (cnt == LAST) begin
                    cnt_n   = 4'd0;
                    state_n = DONE;
                    if (op_rd) read_data_n[31:16] = sram_dq_i;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // SRAM pins are computed from the next state so they are registered yet line up with it.
    always_comb begin
        sram_addr_n  = sram_addr;
        sram_dq_o_n  = sram_dq_o;
        sram_dq_oe_n = 1'b0;
        sram_we_n_n  = 1'b1;
        sram_oe_n_n  = 1'b1;
        if (state_n == LO || state_n == HI) begin
            sram_addr_n = {word_n, (state_n == HI)};
            if (op_rd_n) begin
                sram_oe_n_n = 1'b0;
            end else begin
                sram_we_n_n  = 1'b0;
                sram_dq_oe_n = 1'b1;
                sram_dq_o_n  = (state_n == HI) ? wdata_n[31:16] : wdata_n[15:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_rd      <= 1'b0;
            word       <= '0;
            wdata      <= '0;
            read_data  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            op_rd      <= op_rd_n;
            word       <= word_n;
            wdata      <= wdata_n;
            read_data  <= read_data_n;
            sram_addr  <= sram_addr_n;
            sram_dq_o  <= sram_dq_o_n;
            sram_dq_oe <= sram_dq_oe_n;
            sram_we_n  <= sram_we_n_n;
            sram_oe_n  <= sram_oe_n_n;
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with ACC_CYCLES=3 and a small async SRAM model.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:(1<<18)-1];

    always #5 clk = ~clk;

    sram_mem_ctrl #(.ADDR_BASE(1024), .ACC_CYCLES(3), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    assign sram_dq_i = !sram_oe_n ? mem[sram_addr] : 16'h0000;

    always @(posedge clk)
        if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle 0 is the negedge at which the request is applied (controller in IDLE).
    task automatic write_access(input logic [31:0] a, input logic [31:0] d, input logic [17:0] lo);
        logic hi;
        @(negedge clk); rd_en = 1'b0; wr_en = 1'b1; address = a; write_data = d; #1;
        check("wr_c0_ready", ready, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); wr_en = 1'b0; #1;
            hi = (c > 3);
            check("wr_addr", sram_addr, lo + 18'(hi));
            check("wr_dq_o", sram_dq_o, hi ? d[31:16] : d[15:0]);
            check("wr_we_n", sram_we_n, 0);
            check("wr_oe_n", sram_oe_n, 1);
            check("wr_dq_oe", sram_dq_oe, 1);
            check("wr_busy", ready, 0);
        end
        @(negedge clk); #1;
        check("wr_done_ready", ready, 1);
        check("wr_done_we_n", sram_we_n, 1);
        check("wr_done_dq_oe", sram_dq_oe, 0);
    endtask

    task automatic read_access(input logic r, input logic w, input logic [31:0] a,
                               input logic [17:0] lo, input logic [31:0] exp);
        @(negedge clk); rd_en = r; wr_en = w; address = a; #1;
        check("rd_c0_ready", ready, 0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); rd_en = 1'b0; wr_en = 1'b0; #1;
            check("rd_addr", sram_addr, lo + 18'(c > 3));
            check("rd_oe_n", sram_oe_n, 0);
            check("rd_we_n", sram_we_n, 1);
            check("rd_dq_oe", sram_dq_oe, 0);
            check("rd_busy", ready, 0);
        end
        @(negedge clk); #1;
        check("rd_done_ready", ready, 1);
        check("rd_done_data", read_data, exp);
        @(negedge clk); #1;
        check("rd_hold_data", read_data, exp);
        check("rd_idle_ready", ready, 1);
    endtask

    initial begin
        int rdy_cnt;
        int waited;
        rst = 1'b1; rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024; write_data = '0;

        // Reset with a read request held
        repeat (2) @(negedge clk);
        #1;
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_read_data", read_data, 0);
        check("rst_addr", sram_addr, 0);
        rst = 1'b0; #1;
        check("post_rst_ready", ready, 0);
        @(negedge clk); rd_en = 1'b0; #1;
        check("post_rst_lo_ready", ready, 0);
        waited = 0;
        while (!ready && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        check("post_rst_done_cycle", waited, 6);

        // Writes, then read-back of the second word
        write_access(32'd1024, 32'hDEADBEEF, 18'd0);
        @(negedge clk); #1;
        check("mem0", mem[0], 16'hBEEF);
        check("mem1", mem[1], 16'hDEAD);
        write_access(32'd1028, 32'h12345678, 18'd2);
        read_access(1'b1, 1'b0, 32'd1028, 18'd2, 32'h12345678);

        // rd_en and wr_en together: read wins, SRAM untouched
        read_access(1'b1, 1'b1, 32'd1024, 18'd0, 32'hDEADBEEF);
        check("both_mem0", mem[0], 16'hBEEF);
        check("both_mem1", mem[1], 16'hDEAD);

        // Inputs changed and request dropped during HI
        @(negedge clk); rd_en = 1'b1; address = 32'd1028; #1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 4) begin rd_en = 1'b0; address = 32'd2000; end
            #1;
            if (c >= 4) check("drop_addr", sram_addr, 3);
        end
        @(negedge clk); #1;
        check("drop_ready", ready, 1);
        check("drop_data", read_data, 32'h12345678);

        // Back-to-back loads with the request held through DONE
        @(negedge clk); rd_en = 1'b1; address = 32'd1024; #1;
        rdy_cnt = int'(ready);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 8) address = 32'd1028;
            if (c == 16) rd_en = 1'b0;
            #1;
            if (c <= 15) rdy_cnt += int'(ready);
            if (c == 7) check("b2b_first_data", read_data, 32'hDEADBEEF);
            if (c == 8) begin
                check("b2b_gap_ready", ready, 0);
                check("b2b_gap_oe_n", sram_oe_n, 1);
            end
            if (c == 9) begin
                check("b2b_second_oe_n", sram_oe_n, 0);
                check("b2b_second_addr", sram_addr, 2);
            end
            if (c == 15) begin
                check("b2b_second_ready", ready, 1);
                check("b2b_second_data", read_data, 32'h12345678);
            end
            if (c == 16) check("b2b_idle_ready", ready, 1);
        end
        check("b2b_ready_pulses", rdy_cnt, 2);

        // Reset in the middle of a write's low half
        @(negedge clk); wr_en = 1'b1; address = 32'd1024; write_data = 32'hCAFEF00D; #1;
        @(negedge clk); wr_en = 1'b0; #1;
        @(negedge clk); rst = 1'b1; #1;
        check("midrst_we_before", sram_we_n, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("midrst_we_n", sram_we_n, 1);
        check("midrst_oe_n", sram_oe_n, 1);
        check("midrst_dq_oe", sram_dq_oe, 0);
        check("midrst_addr", sram_addr, 0);
        check("midrst_dq_o", sram_dq_o, 0);
        check("midrst_read_data", read_data, 0);
        check("midrst_ready", ready, 1);
        @(negedge clk); #1;
        check("midrst_idle_ready", ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
